// File: rtl/controller_sequencer.sv
// Six-step ring counter and control-word decoder for a simple accumulator CPU.
// Optional halt support is compiled in with `define CTRL_HALT_EN.
module controller_sequencer #(
  parameter logic [3:0] HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        hlt
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;

  localparam logic [11:0] CON_NOP = 12'h3E3;

  logic hlt_op;
  logic halt_req;

  assign hlt_op = (opcode == HLT_OPCODE);

`ifdef CTRL_HALT_EN
  logic halted;

  assign halt_req = (t_state == T4) && hlt_op;

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      halted <= 1'b0;
    end else if (halt_req) begin
      halted <= 1'b1;
    end
  end

  assign hlt = halted;
`else
  assign halt_req = 1'b0;
  assign hlt      = 1'b0;
`endif

  // Ring advances on the falling edge so con is settled by the next rising edge.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      t_state <= T1;
    end else if (!hlt && !halt_req) begin
      t_state <= {t_state[4:0], t_state[5]};
    end
  end

  always_comb begin
    con = CON_NOP;
    if (!hlt) begin
      case (t_state)
        T1: con = 12'h5E3;
        T2: con = 12'hBE3;
        T3: con = 12'h263;
        T4: begin
          if (!hlt_op) begin
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB: con = 12'h1A3;
              OP_OUT:                 con = 12'h3F2;
              default:                con = CON_NOP;
            endcase
          end
        end
        T5: begin
          if (!hlt_op) begin
            case (opcode)
              OP_LDA:         con = 12'h2C3;
              OP_ADD, OP_SUB: con = 12'h2E1;
              default:        con = CON_NOP;
            endcase
          end
        end
        T6: begin
          if (!hlt_op) begin
            case (opcode)
              OP_ADD:  con = 12'h3C7;
              OP_SUB:  con = 12'h3CF;
              default: con = CON_NOP;
            endcase
          end
        end
        default: con = CON_NOP;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_sequencer.sv
// Randomized bench for controller_sequencer against a step-index reference model.
// Honours `define CTRL_HALT_EN the same way as the design.
module tb_controller_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        hlt;

  int checks   = 0;
  int failures = 0;

  int s      = 0;
  bit halted = 1'b0;

`ifdef CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  controller_sequencer dut (
    .clk     (clk),
    .clr     (clr),
    .opcode  (opcode),
    .con     (con),
    .t_state (t_state),
    .hlt     (hlt)
  );

  always #5 clk = ~clk;

  // Control word expected for machine step st (0 = T1) under the instruction table.
  function automatic logic [11:0] exp_con(int st, bit h, logic [3:0] op);
    logic [11:0] fetch [3];
    fetch[0] = 12'h5E3;
    fetch[1] = 12'hBE3;
    fetch[2] = 12'h263;
    if (h) return 12'h3E3;
    if (st < 3) return fetch[st];
    if (op == 4'hF) return 12'h3E3;
    case (op)
      4'h0: return (st == 3) ? 12'h1A3 : (st == 4) ? 12'h2C3 : 12'h3E3;
      4'h1: return (st == 3) ? 12'h1A3 : (st == 4) ? 12'h2E1 : 12'h3C7;
      4'h2: return (st == 3) ? 12'h1A3 : (st == 4) ? 12'h2E1 : 12'h3CF;
      4'hE: return (st == 3) ? 12'h3F2 : 12'h3E3;
      default: return 12'h3E3;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %03h expected %03h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [5:0] ring;
    ring = 6'(1 << s);
    check_val({tag, ".t_state"}, {6'b0, t_state}, {6'b0, ring});
    check_val({tag, ".hlt"}, {11'b0, hlt}, {11'b0, halted});
    check_val({tag, ".con"}, con, exp_con(s, halted, opcode));
    check_val({tag, ".ep_ea"}, {11'b0, con[10] & con[4]}, 12'h000);
    check_val({tag, ".cp_t2"}, {11'b0, con[11] & (t_state != 6'h02)}, 12'h000);
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    #1;
    if (!clr && !halted) begin
      if (HALT_EN && s == 3 && opcode == 4'hF) halted = 1'b1;
      else s = (s + 1) % 6;
    end
    check_all(tag);
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    s = 0;
    halted = 1'b0;
    check_all("clr_assert");
    tick("clr_held");
    @(posedge clk);
    #1 clr = 1'b0;
    check_all("clr_release");
  endtask

  function automatic logic [3:0] pick_op();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 4'h0;
      1: return 4'h1;
      2: return 4'h2;
      3: return 4'hE;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    clr    = 1'b1;
    opcode = 4'h0;
    #3;
    check_all("reset");
    @(posedge clk);
    #1 clr = 1'b0;
    check_all("reset_release");

    for (int i = 0; i < 12; i++) tick("lda_run");
    opcode = 4'h2;
    for (int i = 0; i < 6; i++) tick("sub_run");
    opcode = 4'h1;
    for (int i = 0; i < 6; i++) tick("add_run");
    opcode = 4'hE;
    for (int i = 0; i < 6; i++) tick("out_run");
    opcode = 4'h7;
    for (int i = 0; i < 6; i++) tick("nop_run");

    // Asynchronous clear while sitting in T5, well before the next edge.
    for (int i = 0; i < 6 && s != 4; i++) tick("seek_t5");
    check_val("at_t5", {6'b0, t_state}, 12'h010);
    #2 clr = 1'b1;
    #1;
    s = 0;
    halted = 1'b0;
    check_all("async_clr");
    @(posedge clk);
    #1 clr = 1'b0;
    check_all("async_release");

    do_clr();
    opcode = 4'hF;
    for (int i = 0; i < 24; i++) tick("hlt_run");
    do_clr();

    for (int i = 0; i < 300; i++) begin
      tick("rand");
      if ($urandom_range(0, 2) == 0) begin
        opcode = pick_op();
        #1 check_all("rand_opchg");
      end
      if ($urandom_range(0, 39) == 0) do_clr();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 SHALL have parameter HLT_OPCODE, default 4'hF: opcode value decoded as HLT.
REQ-002 SHALL have port clk, input, 1, system clock; ring advances on the falling edge.
REQ-003 SHALL have port clr, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port opcode, input, 4: instruction-register upper nibble, valid in T4-T6.
REQ-005 SHALL have port con, output, 12: control word, bit order {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n} (bit 11 to bit 0).
REQ-006 SHALL have port t_state, output, 6: one-hot ring; bit0 = T1 ... bit5 = T6.
REQ-007 SHALL have port hlt, output, 1: halted flag.

Function
REQ-008 SHALL advance a 6-state one-hot ring T1->T2->...->T6->T1 on every negedge clk while not halted, so con is stable at the next posedge for the program counter and registers.
REQ-009 SHALL drive con combinationally from t_state and opcode; con SHALL change only after a ring change or an opcode change.
REQ-010 SHALL produce the fetch words for all opcodes: T1 = 12'h5E3 (ep, lm_n=0); T2 = 12'hBE3 (cp); T3 = 12'h263 (ce_n=0, li_n=0).
REQ-011 LDA (4'h0) SHALL produce T4 = 12'h1A3, T5 = 12'h2C3, T6 = 12'h3E3.
REQ-012 ADD (4'h1) SHALL produce T4 = 12'h1A3, T5 = 12'h2E1, T6 = 12'h3C7.
REQ-013 SUB (4'h2) SHALL produce T4 = 12'h1A3, T5 = 12'h2E1, T6 = 12'h3CF.
REQ-014 OUT (4'hE) SHALL produce T4 = 12'h3F2, T5 = 12'h3E3, T6 = 12'h3E3.
REQ-015 Undefined opcodes SHALL execute as NOP: T4-T6 = 12'h3E3; the ring continues normally.
REQ-016 cp SHALL be high only in T2, giving exactly one PC increment per 6-cycle instruction.
REQ-017 ep SHALL be high only in T1; ep and ea SHALL never be high simultaneously (no W-bus contention).
REQ-018 A ring wrap from T6 to T1 SHALL occur on the same negedge as any other advance, with no idle cycle.
REQ-019 An opcode change during T1-T3 SHALL have no effect on con.

Reset
REQ-020 While clr=1, regardless of clk: t_state = 6'b000001, hlt = 0, con = 12'h5E3.
REQ-021 clr asserted mid-instruction (any of T2-T6, or while halted) SHALL immediately force the REQ-020 values; no pending control word SHALL persist.
REQ-022 After clr falls, the first negedge SHALL move the ring to T2.

Configuration
REQ-023 Macro CTRL_HALT_EN SHALL gate the halt feature.
REQ-024 With CTRL_HALT_EN defined: in T4 with opcode == HLT_OPCODE, con = 12'h3E3; the next negedge SHALL set hlt=1 and freeze t_state at T4, and con SHALL stay 12'h3E3 until clr.
REQ-025 Without CTRL_HALT_EN: HLT_OPCODE SHALL decode as NOP (REQ-015), hlt SHALL be tied to 0, and the ring never freezes.

Verification
REQ-026 clr pulse, then 12 negedges with opcode=4'h0 -> t_state cycles 01,02,04,08,10,20,01... and con sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, repeated twice.
REQ-027 opcode=4'h2 held -> T5 = 2E1, T6 = 3CF; opcode=4'h1 -> T6 = 3C7; opcode=4'hE -> T4 = 3F2.
REQ-028 opcode=4'h7 -> T4-T6 all 3E3; cp high once per 6 negedges.
REQ-029 CTRL_HALT_EN defined, opcode=4'hF -> hlt=1 after the T4 negedge, t_state=6'h08 and con=3E3 for 20 further cycles; then clr=1 -> t_state=01, hlt=0, con=5E3.
REQ-030 clr asserted asynchronously between edges while in T5 -> t_state=01 and con=5E3 before the next clk edge; CTRL_HALT_EN undefined with opcode=4'hF -> no halt, ring wraps to T1.
REQ-031 Every scenario: ep&ea never 1, and cp is high only when t_state=6'h02.
